tick_pwm: RTL and testbench

Programmable PWM and period-event generator fed by the clock divider's `clk_div6` and `clk_div12` outputs. It turns each level change of the selected divider output into a one-cycle tick. It counts ticks against a double-buffered period/duty pair and drives a registered `pwm_out`. This block is the divider's downstream consumer and runs in the same `clk` domain.

---
 rtl/tick_pwm_pkg.sv | 16 +
 rtl/tick_pwm_if.sv | 34 +++
 rtl/tick_pwm_edge_tick.sv | 37 +++
 rtl/tick_pwm.sv | 139 +++++++++++++
 tb/tb_tick_pwm.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tick_pwm_pkg.sv
// Shared types and constants for the tick-driven PWM generator.
// Contents: FSM state type, tick source select encodings, default counter width.
package tick_pwm_pkg;

    localparam int unsigned TICK_PWM_CNT_W = 8;

    localparam logic TICK_SEL_DIV6  = 1'b0;
    localparam logic TICK_SEL_DIV12 = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } tick_pwm_state_t;

endpackage

// File: rtl/tick_pwm_if.sv
// Control/status bundle between the PWM generator and its controller.
// master: drives divider levels, tick select, start/stop, period/duty load.
// slave : the generator; returns load_ready, pwm_out, period_done, busy, cnt.
interface tick_pwm_if
    import tick_pwm_pkg::*;
#(
    parameter int unsigned CNT_W = TICK_PWM_CNT_W
) ();

    logic             div6_in;
    logic             div12_in;
    logic             tick_sel;
    logic             start;
    logic             stop;
    logic             load_valid;
    logic             load_ready;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] duty;
    logic             pwm_out;
    logic             period_done;
    logic             busy;
    logic [CNT_W-1:0] cnt;

    modport master (
        output div6_in, div12_in, tick_sel, start, stop, load_valid, period, duty,
        input  load_ready, pwm_out, period_done, busy, cnt
    );

    modport slave (
        input  div6_in, div12_in, tick_sel, start, stop, load_valid, period, duty,
        output load_ready, pwm_out, period_done, busy, cnt
    );

endinterface

// File: rtl/tick_pwm_edge_tick.sv
// Converts every level change of one divider output into a one-cycle tick.
// Ports: clk, reset (async, active-low), lvl_i (divider level), tick_c (comb tick).
// TICK_PWM_SYNC_EN: when defined, lvl_i passes a 2-flop synchronizer first,
// delaying the tick by exactly two clk cycles.
module tick_pwm_edge_tick (
    input  logic clk,
    input  logic reset,
    input  logic lvl_i,
    output logic tick_c
);

    logic lvl_s;
    logic dly_q;

`ifdef TICK_PWM_SYNC_EN
    logic [1:0] sync_q;

    // Two-stage synchronizer ahead of the edge detector
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sync_q <= 2'b00;
        else        sync_q <= {sync_q[0], lvl_i};
    end

    assign lvl_s = sync_q[1];
`else
    assign lvl_s = lvl_i;
`endif

    // Delay flop updates every cycle so a later source switch sees no stale level
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) dly_q <= 1'b0;
        else        dly_q <= lvl_s;
    end

    assign tick_c = lvl_s ^ dly_q;

endmodule

// File: rtl/tick_pwm.sv
// PWM / period-event generator clocked by ticks from the divider outputs.
// Ports: clk, reset (async, active-low), bus (tick_pwm_if.slave):
//   inputs  div6_in, div12_in, tick_sel, start, stop, load_valid, period, duty
//   outputs load_ready, pwm_out, period_done, busy, cnt (all registered)
// period = 0 means 2^CNT_W ticks. New period/duty are double-buffered and
// applied on start from idle or on a period wrap.
// TICK_PWM_SYNC_EN: adds a 2-flop synchronizer on each divider input.
module tick_pwm
    import tick_pwm_pkg::*;
#(
    parameter int unsigned CNT_W = TICK_PWM_CNT_W
) (
    input logic       clk,
    input logic       reset,
    tick_pwm_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    tick_pwm_state_t  state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] per_act_q, per_act_d;
    logic [CNT_W-1:0] duty_act_q, duty_act_d;
    logic [CNT_W-1:0] per_sh_q, per_sh_d;
    logic [CNT_W-1:0] duty_sh_q, duty_sh_d;
    logic             ready_q, ready_d;
    logic             pwm_q, pwm_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    logic             tick6_c, tick12_c, tick_c;
    logic             wrap_c;
    logic             apply_c;

    tick_pwm_edge_tick u_edge_tick_div6 (
        .clk    (clk),
        .reset  (reset),
        .lvl_i  (bus.div6_in),
        .tick_c (tick6_c)
    );

    tick_pwm_edge_tick u_edge_tick_div12 (
        .clk    (clk),
        .reset  (reset),
        .lvl_i  (bus.div12_in),
        .tick_c (tick12_c)
    );

    assign tick_c = (bus.tick_sel == TICK_SEL_DIV12) ? tick12_c : tick6_c;

    // Modular compare: per_act = 0 wraps at all-ones, i.e. 2^CNT_W ticks
    assign wrap_c = (cnt_q == (per_act_q - CNT_ONE));

    // Next-state, counter, shadow/active buffering and output decode
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        per_act_d  = per_act_q;
        duty_act_d = duty_act_q;
        per_sh_d   = per_sh_q;
        duty_sh_d  = duty_sh_q;
        ready_d    = ready_q;
        done_d     = 1'b0;
        apply_c    = 1'b0;

        if (bus.load_valid && ready_q) begin
            per_sh_d  = bus.period;
            duty_sh_d = bus.duty;
            ready_d   = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    apply_c = ~ready_q;
                end
            end
            ST_RUN, ST_DRAIN: begin
                if ((state_q == ST_RUN) && bus.stop) state_d = ST_DRAIN;
                if (tick_c) begin
                    if (wrap_c) begin
                        cnt_d   = '0;
                        done_d  = 1'b1;
                        apply_c = ~ready_q;
                        if (state_q == ST_DRAIN) state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A pending shadow never coincides with an accepted load (ready_q differs)
        if (apply_c) begin
            per_act_d  = per_sh_q;
            duty_act_d = duty_sh_q;
            ready_d    = 1'b1;
        end

        busy_d = (state_d != ST_IDLE);
        pwm_d  = (state_d != ST_IDLE) && (cnt_d < duty_act_d);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            per_act_q  <= '0;
            duty_act_q <= '0;
            per_sh_q   <= '0;
            duty_sh_q  <= '0;
            ready_q    <= 1'b1;
            pwm_q      <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            per_act_q  <= per_act_d;
            duty_act_q <= duty_act_d;
            per_sh_q   <= per_sh_d;
            duty_sh_q  <= duty_sh_d;
            ready_q    <= ready_d;
            pwm_q      <= pwm_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.load_ready  = ready_q;
    assign bus.pwm_out     = pwm_q;
    assign bus.period_done = done_q;
    assign bus.busy        = busy_q;
    assign bus.cnt         = cnt_q;

endmodule

// File: tb/tb_tick_pwm.sv
// Directed self-checking bench for tick_pwm. Divider levels come from a
// free-running model (toggle every 6 / 12 clk); expectations are phase-free
// cycle counts measured between period_done pulses and tick events.
module tb_tick_pwm;

    localparam int unsigned CW = 8;
`ifdef TICK_PWM_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    int   m_len, m_high, m_rdy, m_ticks;
    int   m_seq[$];

    always #5 clk = ~clk;

    tick_pwm_if #(.CNT_W(CW)) bus ();

    tick_pwm #(.CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Divider model: div6 toggles every 6 clk, div12 every 12 clk
    initial begin : div_gen
        int c6;
        int c12;
        c6 = 0;
        c12 = 0;
        bus.div6_in  = 1'b0;
        bus.div12_in = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            c6++;
            c12++;
            if (c6 == 6) begin c6 = 0; bus.div6_in = ~bus.div6_in; end
            if (c12 == 12) begin c12 = 0; bus.div12_in = ~bus.div12_in; end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input int p, input int d);
        checks++;
        if (bus.load_ready !== 1'b1) begin errors++; $display("FAIL load_ready_before: got %b required 1", bus.load_ready); end
        bus.period = CW'(p);
        bus.duty = CW'(d);
        bus.load_valid = 1'b1;
        @(negedge clk);
        bus.load_valid = 1'b0;
        checks++;
        if (bus.load_ready !== 1'b0) begin errors++; $display("FAIL load_ready_after: got %b required 0", bus.load_ready); end
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (bus.period_done) break;
        end
        checks++;
        if (bus.period_done !== 1'b1) begin errors++; $display("FAIL wait_done: period_done=%b after %0d cycles, required 1", bus.period_done, bound); end
    endtask

    task automatic wait_cnt(input int val, input int bound);
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (bus.cnt == CW'(val)) break;
        end
        checks++;
        if (bus.cnt !== CW'(val)) begin errors++; $display("FAIL wait_cnt: cnt=%0d required %0d", bus.cnt, val); end
    endtask

    // Cycles until the next cnt change; returns bound on timeout
    task automatic tick_gap(input int bound, output int n);
        logic [CW-1:0] c;
        c = bus.cnt;
        n = bound;
        for (int i = 1; i <= bound; i++) begin
            @(negedge clk);
            if (bus.cnt != c) begin n = i; break; end
        end
    endtask

    // Starts at a period_done sample; runs up to and including the next one
    task automatic measure_period(input int bound);
        int prev;
        m_len = 0; m_high = 0; m_rdy = 0; m_ticks = 0;
        m_seq.delete();
        prev = int'(bus.cnt);
        for (int i = 0; i < bound; i++) begin
            m_high += int'(bus.pwm_out);
            m_rdy  += int'(bus.load_ready);
            @(negedge clk);
            m_len++;
            if (int'(bus.cnt) != prev) begin
                m_seq.push_back(int'(bus.cnt));
                m_ticks++;
                prev = int'(bus.cnt);
            end
            if (bus.period_done) break;
        end
        checks++;
        if (bus.period_done !== 1'b1) begin errors++; $display("FAIL measure_timeout: period_done=%b after %0d cycles, required 1", bus.period_done, m_len); end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.tick_sel = 1'b0; bus.start = 1'b0; bus.stop = 1'b0;
        bus.load_valid = 1'b0; bus.period = '0; bus.duty = '0;
        step(3);
        checks++; if (bus.pwm_out !== 1'b0) begin errors++; $display("FAIL reset_pwm: got %b required 0", bus.pwm_out); end
        checks++; if (bus.period_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b required 0", bus.period_done); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", bus.busy); end
        checks++; if (bus.load_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", bus.load_ready); end
        checks++; if (bus.cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt: got %0d required 0", bus.cnt); end
        reset = 1'b1;
        step(20);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b required 0", bus.busy); end
        checks++; if (bus.cnt !== 8'd0) begin errors++; $display("FAIL idle_cnt: got %0d required 0", bus.cnt); end
    endtask

    task automatic test_basic();
        int s[4];
        bus.tick_sel = 1'b0;
        do_load(4, 1);
        pulse_start();
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL start_busy: got %b required 1", bus.busy); end
        checks++; if (bus.cnt !== 8'd0) begin errors++; $display("FAIL start_cnt: got %0d required 0", bus.cnt); end
        checks++; if (bus.pwm_out !== 1'b1) begin errors++; $display("FAIL start_pwm: got %b required 1", bus.pwm_out); end
        checks++; if (bus.load_ready !== 1'b1) begin errors++; $display("FAIL start_ready: got %b required 1", bus.load_ready); end
        wait_done(100);
        measure_period(100);
        checks++; if (m_len != 24) begin errors++; $display("FAIL basic_period_len: got %0d required 24", m_len); end
        checks++; if (m_high != 6) begin errors++; $display("FAIL basic_high: got %0d required 6", m_high); end
        for (int i = 0; i < 4; i++) s[i] = (i < m_seq.size()) ? m_seq[i] : -1;
        checks++;
        if (m_seq.size() != 4 || s[0] != 1 || s[1] != 2 || s[2] != 3 || s[3] != 0) begin
            errors++;
            $display("FAIL basic_cnt_seq: got n=%0d %0d,%0d,%0d,%0d required 1,2,3,0", m_seq.size(), s[0], s[1], s[2], s[3]);
        end
        checks++; if (bus.cnt !== 8'd0) begin errors++; $display("FAIL done_cnt: got %0d required 0", bus.cnt); end
        step(1);
        checks++; if (bus.period_done !== 1'b0) begin errors++; $display("FAIL done_width: got %b required 0", bus.period_done); end
    endtask

    task automatic test_duty();
        do_load(4, 0);
        wait_done(100);
        checks++; if (bus.load_ready !== 1'b1) begin errors++; $display("FAIL duty0_ready: got %b required 1", bus.load_ready); end
        measure_period(100);
        checks++; if (m_len != 24) begin errors++; $display("FAIL duty0_len: got %0d required 24", m_len); end
        checks++; if (m_high != 0) begin errors++; $display("FAIL duty0_high: got %0d required 0", m_high); end
        do_load(4, 4);
        wait_done(100);
        measure_period(100);
        checks++; if (m_len != 24) begin errors++; $display("FAIL duty4_len: got %0d required 24", m_len); end
        checks++; if (m_high != 24) begin errors++; $display("FAIL duty4_high: got %0d required 24", m_high); end
    endtask

    task automatic test_reload();
        step(3);
        do_load(2, 1);
        measure_period(100);
        checks++; if (m_len != 20) begin errors++; $display("FAIL reload_old_len: got %0d required 20", m_len); end
        checks++; if (m_rdy != 0) begin errors++; $display("FAIL reload_ready_low: ready cycles %0d required 0", m_rdy); end
        checks++; if (bus.load_ready !== 1'b1) begin errors++; $display("FAIL reload_ready_wrap: got %b required 1", bus.load_ready); end
        checks++; if (bus.pwm_out !== 1'b1) begin errors++; $display("FAIL reload_pwm_wrap: got %b required 1", bus.pwm_out); end
        measure_period(100);
        checks++; if (m_len != 12) begin errors++; $display("FAIL reload_new_len: got %0d required 12", m_len); end
        checks++; if (m_high != 6) begin errors++; $display("FAIL reload_new_high: got %0d required 6", m_high); end
        checks++; if (m_ticks != 2) begin errors++; $display("FAIL reload_new_ticks: got %0d required 2", m_ticks); end
    endtask

    task automatic test_stop();
        int k;
        do_load(4, 1);
        wait_done(100);
        wait_cnt(1, 20);
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        k = 0;
        for (int i = 1; i <= 40; i++) begin
            bus.stop = (i == 4);
            @(negedge clk);
            k = i;
            if (!bus.busy) break;
        end
        bus.stop = 1'b0;
        checks++; if (k != 17) begin errors++; $display("FAIL drain_cycles: got %0d required 17", k); end
        checks++; if (bus.cnt !== 8'd0) begin errors++; $display("FAIL drain_cnt: got %0d required 0", bus.cnt); end
        checks++; if (bus.pwm_out !== 1'b0) begin errors++; $display("FAIL drain_pwm: got %b required 0", bus.pwm_out); end
        checks++; if (bus.period_done !== 1'b1) begin errors++; $display("FAIL drain_done: got %b required 1", bus.period_done); end
        step(30);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_after_drain: got %b required 0", bus.busy); end
        checks++; if (bus.cnt !== 8'd0) begin errors++; $display("FAIL idle_cnt_hold: got %0d required 0", bus.cnt); end
        bus.start = 1'b1;
        bus.stop = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.stop = 1'b0;
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL start_stop_busy: got %b required 1", bus.busy); end
        step(40);
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL start_stop_run: got %b required 1", bus.busy); end
    endtask

    task automatic test_tick_sel();
        int n;
        wait_done(100);
        tick_gap(20, n);
        step(2);
        bus.tick_sel = 1'b1;
        tick_gap(30, n);
        n += 2;
        checks++; if (n != 6 && n != 12) begin errors++; $display("FAIL sel_switch_gap: got %0d required 6 or 12", n); end
        tick_gap(30, n);
        checks++; if (n != 12) begin errors++; $display("FAIL sel_div12_gap1: got %0d required 12", n); end
        tick_gap(30, n);
        checks++; if (n != 12) begin errors++; $display("FAIL sel_div12_gap2: got %0d required 12", n); end
    endtask

    task automatic test_period0();
        do_load(0, 128);
        wait_done(100);
        measure_period(4000);
        checks++; if (m_len != 3072) begin errors++; $display("FAIL p0_len: got %0d required 3072", m_len); end
        checks++; if (m_high != 1536) begin errors++; $display("FAIL p0_high: got %0d required 1536", m_high); end
        checks++; if (m_ticks != 256) begin errors++; $display("FAIL p0_ticks: got %0d required 256", m_ticks); end
        bus.tick_sel = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_load(4, 1);
        wait_cnt(2, 100);
        checks++; if (bus.pwm_out !== 1'b1) begin errors++; $display("FAIL pre_reset_pwm: got %b required 1", bus.pwm_out); end
        #2;
        reset = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL async_busy: got %b required 0", bus.busy); end
        checks++; if (bus.pwm_out !== 1'b0) begin errors++; $display("FAIL async_pwm: got %b required 0", bus.pwm_out); end
        checks++; if (bus.cnt !== 8'd0) begin errors++; $display("FAIL async_cnt: got %0d required 0", bus.cnt); end
        checks++; if (bus.load_ready !== 1'b1) begin errors++; $display("FAIL async_ready: got %b required 1", bus.load_ready); end
        checks++; if (bus.period_done !== 1'b0) begin errors++; $display("FAIL async_done: got %b required 0", bus.period_done); end
        step(3);
        reset = 1'b1;
        step(2);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %b required 0", bus.busy); end
    endtask

    task automatic test_latency();
        logic          lvl;
        logic [CW-1:0] c;
        int            n;
        int            seen;
        do_load(4, 1);
        pulse_start();
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            lvl = bus.div6_in;
            @(negedge clk);
            if (bus.div6_in != lvl) begin seen = 1; break; end
        end
        checks++; if (seen != 1) begin errors++; $display("FAIL lat_toggle_seen: got %0d required 1", seen); end
        c = bus.cnt;
        tick_gap(10, n);
        checks++; if (n != LAT) begin errors++; $display("FAIL tick_latency: got %0d required %0d", n, LAT); end
        checks++; if (bus.cnt !== CW'(c + 8'd1)) begin errors++; $display("FAIL lat_cnt_inc: got %0d required %0d", bus.cnt, c + 8'd1); end
    endtask

    initial begin : main
        test_reset();
        test_basic();
        test_duty();
        test_reload();
        test_stop();
        test_tick_sel();
        test_period0();
        test_reset_mid();
        test_latency();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
